// File: rtl/core_types_pkg.sv
// Core-wide sizing constants shared by the PRF writeback path.
package core_types_pkg;

  localparam int PRF_WR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int PR_COUNT           = 128;
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int XLEN               = 32;

endpackage

// File: rtl/prf_wb_bank_arbiter_if.sv
// Writeback requester bus and registered per-bank PRF write ports.
interface prf_wb_bank_arbiter_if #(
  parameter int PRF_WR_COUNT   = core_types_pkg::PRF_WR_COUNT,
  parameter int PRF_BANK_COUNT = core_types_pkg::PRF_BANK_COUNT,
  parameter int PR_COUNT       = core_types_pkg::PR_COUNT,
  parameter int XLEN           = core_types_pkg::XLEN
) ();
  import core_types_pkg::*;

  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);

  logic [PRF_WR_COUNT-1:0]                     WB_valid_by_req;
  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   WB_PR_by_req;
  logic [PRF_WR_COUNT-1:0][XLEN-1:0]           WB_data_by_req;
  logic [PRF_WR_COUNT-1:0]                     WB_ready_by_req;

  logic [PRF_BANK_COUNT-1:0]                   bank_WB_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] bank_WB_PR_by_bank;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         bank_WB_data_by_bank;

  // Requesters (and the bench) are the master side; the arbiter is the slave.
  modport master (
    output WB_valid_by_req, WB_PR_by_req, WB_data_by_req,
    input  WB_ready_by_req,
    input  bank_WB_valid_by_bank, bank_WB_PR_by_bank, bank_WB_data_by_bank
  );

  modport slave (
    input  WB_valid_by_req, WB_PR_by_req, WB_data_by_req,
    output WB_ready_by_req,
    output bank_WB_valid_by_bank, bank_WB_PR_by_bank, bank_WB_data_by_bank
  );

endinterface

// File: rtl/prf_wb_bank_rr_picker.sv
// One-hot picker for a single PRF bank. Round-robin from ptr_i when
// PRF_WB_ARB_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
module prf_wb_bank_rr_picker #(
  parameter int REQ_COUNT = core_types_pkg::PRF_WR_COUNT
`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
  ,
  parameter int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
`endif
) (
  input  logic [REQ_COUNT-1:0] req_i,
`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
  input  logic [PTR_W-1:0]     ptr_i,
`endif
  output logic [REQ_COUNT-1:0] gnt_o
);
  import core_types_pkg::*;

  logic found;

`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
  logic [PTR_W:0] idx;

  // Walk ptr, ptr+1, ... wrapping at REQ_COUNT; sum never exceeds 2*REQ_COUNT-2.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(REQ_COUNT)) begin
        idx = idx - (PTR_W+1)'(REQ_COUNT);
      end
      if (!found && req_i[idx[PTR_W-1:0]]) begin
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (!found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/prf_wb_bank_arbiter.sv
// Routes writeback requesters onto per-bank PRF write ports, one grant per bank
// per cycle. Define PRF_WB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module prf_wb_bank_arbiter #(
  parameter int PRF_WR_COUNT   = core_types_pkg::PRF_WR_COUNT,
  parameter int PRF_BANK_COUNT = core_types_pkg::PRF_BANK_COUNT,
  parameter int PR_COUNT       = core_types_pkg::PR_COUNT,
  parameter int XLEN           = core_types_pkg::XLEN
) (
  input  logic                  CLK,
  input  logic                  nRST,
  prf_wb_bank_arbiter_if.slave  wb_if
);
  import core_types_pkg::*;

  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);

  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] bankReq;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] bankGnt;
  logic [PRF_WR_COUNT-1:0]                     readyAll;

  logic [PRF_BANK_COUNT-1:0]                   bankValid_q, bankValid_d;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] bankPR_q,    bankPR_d;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         bankData_q,  bankData_d;

`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;
  logic [PRF_BANK_COUNT-1:0][PTR_W-1:0] ptr_q, ptr_d;
`endif

  // The low PR bits select the bank.
  always_comb begin
    bankReq = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        bankReq[b][i] = wb_if.WB_valid_by_req[i] &&
          (wb_if.WB_PR_by_req[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
    prf_wb_bank_rr_picker #(
      .REQ_COUNT (PRF_WR_COUNT)
    ) u_picker (
      .req_i (bankReq[gb]),
`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
      .ptr_i (ptr_q[gb]),
`endif
      .gnt_o (bankGnt[gb])
    );
  end

  always_comb begin
    readyAll = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      readyAll = readyAll | bankGnt[b];
    end
  end

  // Ungranted banks drop valid but keep the last PR/data.
  always_comb begin
    bankValid_d = '0;
    bankPR_d    = bankPR_q;
    bankData_d  = bankData_q;
`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (bankGnt[b][i]) begin
          bankValid_d[b] = 1'b1;
          bankPR_d[b]    = wb_if.WB_PR_by_req[i];
          bankData_d[b]  = wb_if.WB_data_by_req[i];
`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
          ptr_d[b]       = (i == PRF_WR_COUNT-1) ? '0 : PTR_W'(i + 1);
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bankValid_q <= '0;
      bankPR_q    <= '0;
      bankData_q  <= '0;
    end else begin
      bankValid_q <= bankValid_d;
      bankPR_q    <= bankPR_d;
      bankData_q  <= bankData_d;
    end
  end

`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign wb_if.WB_ready_by_req       = readyAll;
  assign wb_if.bank_WB_valid_by_bank = bankValid_q;
  assign wb_if.bank_WB_PR_by_bank    = bankPR_q;
  assign wb_if.bank_WB_data_by_bank  = bankData_q;

endmodule

// File: tb/tb_prf_wb_bank_arbiter.sv
// Scoreboard bench for prf_wb_bank_arbiter; expectations follow PRF_WB_ARB_ROUND_ROBIN_EN.
module tb_prf_wb_bank_arbiter;

  localparam int WR    = 7;
  localparam int BANKS = 4;
  localparam int LOGPR = 7;
  localparam int XL    = 32;

  typedef struct {
    int            due;
    logic [WR-1:0] ready;
  } rdyExp_t;

  typedef struct {
    int                          due;
    logic [BANKS-1:0]            valid;
    logic [BANKS-1:0][LOGPR-1:0] pr;
    logic [BANKS-1:0][XL-1:0]    data;
  } bankExp_t;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int negCount = 0;

  rdyExp_t  readyQ[$];
  bankExp_t bankQ[$];

  logic [BANKS-1:0][LOGPR-1:0] shPR;
  logic [BANKS-1:0][XL-1:0]    shData;

  always #5 CLK = ~CLK;

  prf_wb_bank_arbiter_if #(
    .PRF_WR_COUNT(WR), .PRF_BANK_COUNT(BANKS), .PR_COUNT(128), .XLEN(XL)
  ) wbIf ();

  prf_wb_bank_arbiter #(
    .PRF_WR_COUNT(WR), .PRF_BANK_COUNT(BANKS), .PR_COUNT(128), .XLEN(XL)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .wb_if (wbIf)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of requests and queues the grant and next-cycle bank expectations.
  task automatic applyStimulus(input logic [WR-1:0] valid,
                               input logic [WR-1:0][LOGPR-1:0] pr,
                               input logic [WR-1:0] expReady);
    rdyExp_t  r;
    bankExp_t e;
    logic [WR-1:0][XL-1:0] data;
    logic [1:0] b;
    @(posedge CLK);
    #1;
    for (int i = 0; i < WR; i++) begin
      data[i] = 32'hC0DE0000 | (32'(pr[i]) << 8) | 32'(i);
    end
    wbIf.WB_valid_by_req = valid;
    wbIf.WB_PR_by_req    = pr;
    wbIf.WB_data_by_req  = data;
    r.due   = negCount;
    r.ready = expReady;
    readyQ.push_back(r);
    e.due   = negCount + 1;
    e.valid = '0;
    for (int i = 0; i < WR; i++) begin
      if (expReady[i]) begin
        b          = pr[i][1:0];
        e.valid[b] = 1'b1;
        shPR[b]    = pr[i];
        shData[b]  = data[i];
      end
    end
    e.pr   = shPR;
    e.data = shData;
    bankQ.push_back(e);
  endtask

  task automatic doReset();
    nRST = 1'b0;
    wbIf.WB_valid_by_req = '0;
    readyQ.delete();
    bankQ.delete();
    shPR   = '0;
    shData = '0;
    #1;
    checkOutput("reset_bank_valid", 64'(wbIf.bank_WB_valid_by_bank), 64'd0);
    checkOutput("reset_bank_pr", 64'(wbIf.bank_WB_PR_by_bank), 64'd0);
    for (int b = 0; b < BANKS; b++) begin
      checkOutput($sformatf("reset_bank%0d_data", b), 64'(wbIf.bank_WB_data_by_bank[b]), 64'd0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  always @(negedge CLK) begin : monitor
    rdyExp_t  r;
    bankExp_t e;
    while (readyQ.size() > 0 && readyQ[0].due <= negCount) begin
      r = readyQ.pop_front();
      checkOutput("ready", 64'(wbIf.WB_ready_by_req), 64'(r.ready));
    end
    while (bankQ.size() > 0 && bankQ[0].due <= negCount) begin
      e = bankQ.pop_front();
      for (int b = 0; b < BANKS; b++) begin
        checkOutput($sformatf("bank%0d_valid", b), 64'(wbIf.bank_WB_valid_by_bank[b]), 64'(e.valid[b]));
        checkOutput($sformatf("bank%0d_pr", b), 64'(wbIf.bank_WB_PR_by_bank[b]), 64'(e.pr[b]));
        checkOutput($sformatf("bank%0d_data", b), 64'(wbIf.bank_WB_data_by_bank[b]), 64'(e.data[b]));
      end
    end
    negCount <= negCount + 1;
  end

  initial begin
    wbIf.WB_valid_by_req = '0;
    wbIf.WB_PR_by_req    = '0;
    wbIf.WB_data_by_req  = '0;
    shPR   = '0;
    shData = '0;
    @(posedge CLK);
    #2;
    doReset();

    // All seven requesters, PRs 0..6: one winner per bank, then the leftovers.
    applyStimulus(7'b1111111, {7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0}, 7'b0001111);
    applyStimulus(7'b1110000, {7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1, 7'd0}, 7'b1110000);

    // Two requesters on distinct banks both win.
    applyStimulus(7'b0001001, {7'd0, 7'd0, 7'd0, 7'd10, 7'd0, 7'd0, 7'd5}, 7'b0001001);
    applyStimulus(7'b0000000, '0, 7'b0000000);

    // Reset mid-traffic with bank 2 holding a write.
    applyStimulus(7'b0000010, {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd6, 7'd0}, 7'b0000010);
    @(posedge CLK);
    #1;
    checkOutput("pre_reset_bank2_valid", 64'(wbIf.bank_WB_valid_by_bank[2]), 64'd1);
    checkOutput("pre_reset_bank2_pr", 64'(wbIf.bank_WB_PR_by_bank[2]), 64'd6);
    #1;
    doReset();

`ifdef PRF_WB_ARB_ROUND_ROBIN_EN
    // Reqs 1, 4, 6 camp on bank 3: rotation 1, 4, 6, 1.
    applyStimulus(7'b1010010, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b0000010);
    applyStimulus(7'b1010010, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b0010000);
    applyStimulus(7'b1010010, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b1000000);
    applyStimulus(7'b1010010, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b0000010);
    // Bank 0 pointer to 6, then 6 wins and the pointer wraps to 0.
    applyStimulus(7'b0100000, {7'd0, 7'd4, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0}, 7'b0100000);
    applyStimulus(7'b1000001, {7'd8, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd12}, 7'b1000000);
    applyStimulus(7'b1000001, {7'd8, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd12}, 7'b0000001);
`else
    // Fixed priority: req 2 always beats req 5 on bank 1.
    applyStimulus(7'b0100100, {7'd0, 7'd13, 7'd0, 7'd0, 7'd9, 7'd0, 7'd0}, 7'b0000100);
    applyStimulus(7'b0100100, {7'd0, 7'd13, 7'd0, 7'd0, 7'd9, 7'd0, 7'd0}, 7'b0000100);
    applyStimulus(7'b0100100, {7'd0, 7'd13, 7'd0, 7'd0, 7'd9, 7'd0, 7'd0}, 7'b0000100);
    applyStimulus(7'b1010010, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b0000010);
    applyStimulus(7'b1010000, {7'd11, 7'd0, 7'd7, 7'd0, 7'd0, 7'd3, 7'd0}, 7'b0010000);
    applyStimulus(7'b1000001, {7'd8, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd12}, 7'b0000001);
`endif

    applyStimulus(7'b0000000, '0, 7'b0000000);
    applyStimulus(7'b0000000, '0, 7'b0000000);

    for (int k = 0; k < 20 && (readyQ.size() > 0 || bankQ.size() > 0); k++) begin
      @(posedge CLK);
    end
    checkOutput("pending_expectations", 64'(readyQ.size() + bankQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prf_wb_bank_arbiter.md
PRF_WB_BANK_ARBITER -- requirements
Module: prf_wb_bank_arbiter

Interface
- REQ-001: Parameter PRF_WR_COUNT, default 7: number of writeback requesters.
- REQ-002: Parameter PRF_BANK_COUNT, default 4: number of PRF banks, each with one write port.
- REQ-003: Parameter PR_COUNT, default 128: physical register count; LOG_PR_COUNT = $clog2(PR_COUNT).
- REQ-004: Parameter XLEN, default 32: data width.
- REQ-005: CLK  in  1  single clock; all state updates on rising edge.
- REQ-006: nRST  in  1  asynchronous, active-low reset.
- REQ-007: WB_valid_by_req  in  [PRF_WR_COUNT]  requester i holds a writeback.
- REQ-008: WB_PR_by_req  in  [PRF_WR_COUNT][LOG_PR_COUNT]  destination physical register.
- REQ-009: WB_data_by_req  in  [PRF_WR_COUNT][XLEN]  writeback data.
- REQ-010: WB_ready_by_req  out  [PRF_WR_COUNT]  grant; writeback accepted this cycle.
- REQ-011: bank_WB_valid_by_bank  out  [PRF_BANK_COUNT]  registered write enable per bank.
- REQ-012: bank_WB_PR_by_bank  out  [PRF_BANK_COUNT][LOG_PR_COUNT]  registered full PR per bank.
- REQ-013: bank_WB_data_by_bank  out  [PRF_BANK_COUNT][XLEN]  registered write data per bank.

Function
- REQ-014: Target bank of requester i is WB_PR_by_req[i][LOG_PRF_BANK_COUNT-1:0].
- REQ-015: Each cycle, each bank grants at most one valid requester targeting it; banks arbitrate independently.
- REQ-016: WB_ready_by_req[i] is combinational: 1 iff WB_valid_by_req[i] and i won its target bank this cycle; never 1 when valid is 0.
- REQ-017: Transfer occurs on valid & ready; winner's PR and data appear on its bank outputs exactly 1 cycle later with bank valid 1.
- REQ-018: Bank with no valid requester drives bank valid 0 next cycle; its PR/data registers hold previous values.
- REQ-019: Requesters not granted keep valid, PR and data stable until granted; the arbiter does not buffer losers.
- REQ-020: Up to PRF_BANK_COUNT grants per cycle when requesters target distinct banks.
- REQ-021: Per-bank state is a priority pointer in [0, PRF_WR_COUNT-1]; arbitration searches from pointer upward, wrapping PRF_WR_COUNT-1 -> 0.
- REQ-022: After grant to requester g, that bank's pointer becomes (g+1) mod PRF_WR_COUNT; with no grant, pointer holds.
- REQ-023: Requester with valid 1 and constant target bank is granted within PRF_WR_COUNT cycles (no starvation) when round-robin is compiled in.

Reset
- REQ-024: While nRST is 0: all bank valid 0, bank PR 0, bank data 0, all pointers 0, asynchronously.
- REQ-025: Requests presented in the cycle nRST deasserts arbitrate normally; in-flight registered writes are discarded by reset.

Configuration
- REQ-026: Macro PRF_WB_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-021..023.
- REQ-027: Macro undefined: fixed priority, lowest requester index wins per bank; pointer registers absent; REQ-023 does not apply.

Structure
- REQ-028: PRF_WR_COUNT, PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, PR_COUNT, LOG_PR_COUNT, XLEN come from core_types_pkg; no new package typedefs required.
- REQ-029: One sub-module, prf_wb_bank_rr_picker: PRF_WR_COUNT-wide request vector plus pointer in, one-hot grant out; instantiated once per bank.

Verification
- REQ-030: Reset mid-traffic: nRST low with bank 2 valid -> all bank valid 0 immediately, pointers 0.
- REQ-031: Req 0 PR 5, req 3 PR 10 same cycle -> both ready; next cycle bank1 valid PR 5, bank2 valid PR 10.
- REQ-032: Reqs 1, 4, 6 all target bank 3 continuously, pointer 0 -> grants 1, 4, 6, 1 on four successive cycles.
- REQ-033: Pointer 6, req 6 and req 0 target bank 0 -> grant 6, pointer wraps to 0; next cycle grant 0.
- REQ-034: All 7 reqs valid, PRs 0..6 -> banks 0..3 each grant one (reqs 0,1,2,3); reqs 4,5,6 granted next cycle.
- REQ-035: Macro undefined, reqs 2 and 5 hold bank 1 for 3 cycles -> req 2 granted all 3 cycles, req 5 never.
